// File: rtl/uart.sv
// Loopback UART: TX FIFO -> transmitter -> internal serial line -> receiver -> RX FIFO.
// Baud tick is DVSR clocks; every start/data bit spans 16 ticks, the stop bit SB_TICK ticks.

module uart_fifo #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic [W-1:0] w_data,
    input  logic         rd,
    output logic [W-1:0] r_data,
    output logic         full,
    output logic         empty
);
    logic [W-1:0]  mem [2**AW];
    logic [AW-1:0] w_ptr, r_ptr, w_ptr_succ, r_ptr_succ;
    logic          wr_ok, rd_ok;

    assign wr_ok      = wr & ~full;
    assign rd_ok      = rd & ~empty;
    assign w_ptr_succ = w_ptr + AW'(1);
    assign r_ptr_succ = r_ptr + AW'(1);
    assign r_data     = mem[r_ptr];

    // NOTE: storage is deliberately not reset; the pointers and flags define validity.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[w_ptr] <= w_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_ptr <= '0;
            r_ptr <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            case ({wr_ok, rd_ok})
                2'b01: begin
                    r_ptr <= r_ptr_succ;
                    full  <= 1'b0;
                    empty <= (r_ptr_succ == w_ptr);
                end
                2'b10: begin
                    w_ptr <= w_ptr_succ;
                    empty <= 1'b0;
                    full  <= (w_ptr_succ == r_ptr);
                end
                2'b11: begin
                    w_ptr <= w_ptr_succ;
                    r_ptr <= r_ptr_succ;
                end
                default: ;
            endcase
        end
    end
endmodule

module uart #(
    parameter int NBITS   = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR    = 54,
    parameter int FIFO_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             twr_en,
    input  logic [NBITS-1:0] twr_data,
    input  logic             rrd_en,
    output logic [NBITS-1:0] rrd_data,
    output logic             tx_full,
    output logic             rx_full,
    output logic             rx_empty
);
    localparam int DW = (DVSR > 2) ? $clog2(DVSR) : 1;
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int NW = (NBITS > 2) ? $clog2(NBITS) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // Baud generator
    logic [DW-1:0] baud_cnt;
    logic          tick;

    assign tick = (baud_cnt == DW'(DVSR - 1));

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || tick) baud_cnt <= '0;
        else               baud_cnt <= baud_cnt + DW'(1);
    end

    // Transmitter
    state_t           tx_state, tx_state_next;
    logic [SW-1:0]    tx_s, tx_s_next;
    logic [NW-1:0]    tx_n, tx_n_next;
    logic [NBITS-1:0] tx_b, tx_b_next, tx_head;
    logic             tx_line, tx_line_next, tx_pop, tx_empty;

    uart_fifo #(.W(NBITS), .AW(FIFO_W)) tx_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr     (twr_en),
        .w_data (twr_data),
        .rd     (tx_pop),
        .r_data (tx_head),
        .full   (tx_full),
        .empty  (tx_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= IDLE;
            tx_s     <= '0;
            tx_n     <= '0;
            tx_b     <= '0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_next;
            tx_s     <= tx_s_next;
            tx_n     <= tx_n_next;
            tx_b     <= tx_b_next;
            tx_line  <= tx_line_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        tx_state_next = tx_state;
        tx_s_next     = tx_s;
        tx_n_next     = tx_n;
        tx_b_next     = tx_b;
        tx_line_next  = tx_line;
        tx_pop        = 1'b0;
        case (tx_state)
            IDLE: begin
                tx_line_next = 1'b1;
                if (!tx_empty) begin
                    tx_pop        = 1'b1;
                    tx_b_next     = tx_head;
                    tx_s_next     = '0;
                    tx_state_next = START;
                end
            end
            START: begin
                tx_line_next = 1'b0;
                if (tick) begin
                    if (tx_s == SW'(15)) begin
                        tx_s_next     = '0;
                        tx_n_next     = '0;
                        tx_state_next = DATA;
                    end else begin
                        tx_s_next = tx_s + SW'(1);
                    end
                end
            end
            DATA: begin
                tx_line_next = tx_b[0];
                if (tick) begin
                    if (tx_s == SW'(15)) begin
                        tx_s_next = '0;
                        tx_b_next = tx_b >> 1;
                        if (tx_n == NW'(NBITS - 1)) tx_state_next = STOP;
                        else                        tx_n_next     = tx_n + NW'(1);
                    end else begin
                        tx_s_next = tx_s + SW'(1);
                    end
                end
            end
            STOP: begin
                tx_line_next = 1'b1;
                if (tick) begin
                    if (tx_s == SW'(SB_TICK - 1)) tx_state_next = IDLE;
                    else                          tx_s_next     = tx_s + SW'(1);
                end
            end
            default: tx_state_next = IDLE;
        endcase
    end

    // Receiver, fed directly from the transmitter's line register
    state_t           rx_state, rx_state_next;
    logic [SW-1:0]    rx_s, rx_s_next;
    logic [NW-1:0]    rx_n, rx_n_next;
    logic [NBITS-1:0] rx_b, rx_b_next;
    logic             rx_done;

    uart_fifo #(.W(NBITS), .AW(FIFO_W)) rx_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr     (rx_done),
        .w_data (rx_b),
        .rd     (rrd_en),
        .r_data (rrd_data),
        .full   (rx_full),
        .empty  (rx_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state <= IDLE;
            rx_s     <= '0;
            rx_n     <= '0;
            rx_b     <= '0;
        end else begin
            rx_state <= rx_state_next;
            rx_s     <= rx_s_next;
            rx_n     <= rx_n_next;
            rx_b     <= rx_b_next;
        end
    end

    always_comb begin
        rx_state_next = rx_state;
        rx_s_next     = rx_s;
        rx_n_next     = rx_n;
        rx_b_next     = rx_b;
        rx_done       = 1'b0;
        case (rx_state)
            IDLE: begin
                if (!tx_line) begin
                    rx_s_next     = '0;
                    rx_state_next = START;
                end
            end
            START: begin
                // Half a bit in: a glitch that is already high again is not a start bit
                if (tick) begin
                    if (rx_s == SW'(7)) begin
                        rx_s_next     = '0;
                        rx_n_next     = '0;
                        rx_state_next = tx_line ? IDLE : DATA;
                    end else begin
                        rx_s_next = rx_s + SW'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (rx_s == SW'(15)) begin
                        rx_s_next = '0;
                        rx_b_next = {tx_line, rx_b[NBITS-1:1]};
                        if (rx_n == NW'(NBITS - 1)) rx_state_next = STOP;
                        else                        rx_n_next     = rx_n + NW'(1);
                    end else begin
                        rx_s_next = rx_s + SW'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (rx_s == SW'(SB_TICK - 1)) begin
                        rx_done       = 1'b1;
                        rx_state_next = IDLE;
                    end else begin
                        rx_s_next = rx_s + SW'(1);
                    end
                end
            end
            default: rx_state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart.sv
// Loopback bench for uart: bytes queued when written, compared in order as they are popped.
// A small DVSR keeps whole-frame scenarios short.

module tb_uart;
    localparam int NBITS   = 8;
    localparam int SB_TICK = 16;
    localparam int DVSR    = 4;
    localparam int FIFO_W  = 4;
    localparam int DEPTH   = 2**FIFO_W;
    localparam int BIT     = 16 * DVSR;
    localparam int FRAME   = (1 + NBITS) * BIT + SB_TICK * DVSR;

    logic             clk = 1'b0;
    logic             reset, twr_en, rrd_en;
    logic [NBITS-1:0] twr_data, rrd_data;
    logic             tx_full, rx_full, rx_empty;

    int               n_checks = 0;
    int               n_fails  = 0;
    logic [NBITS-1:0] sb [$];

    always #5 clk = ~clk;

    uart #(.NBITS(NBITS), .SB_TICK(SB_TICK), .DVSR(DVSR), .FIFO_W(FIFO_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .twr_en   (twr_en),
        .twr_data (twr_data),
        .rrd_en   (rrd_en),
        .rrd_data (rrd_data),
        .tx_full  (tx_full),
        .rx_full  (rx_full),
        .rx_empty (rx_empty)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Every accepted pop is compared against the oldest expected byte
    always @(negedge clk) begin
        if (!reset && rrd_en && !rx_empty) begin
            if (sb.size() == 0) check("rx_unexpected_byte", 32'(sb.size()), 32'd1);
            else                check("rx_data", 32'(rrd_data), 32'(sb.pop_front()));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    task automatic write_byte(input logic [NBITS-1:0] b);
        twr_en   = 1'b1;
        twr_data = b;
        tick(1);
        twr_en   = 1'b0;
    endtask

    task automatic wait_not_full(input string tag, input int budget);
        int n = 0;
        while (tx_full && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, 32'(tx_full), 32'd0);
    endtask

    task automatic wait_rx(input string tag, input int budget, output int cycles);
        cycles = 0;
        while (rx_empty && cycles < budget) begin
            tick(1);
            cycles++;
        end
        check(tag, 32'(rx_empty), 32'd0);
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        rrd_en = 1'b1;
        while (sb.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, 32'(sb.size()), 32'd0);
        tick(2);
        rrd_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before the end of the test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NBITS-1:0] burst [7];
        logic [NBITS-1:0] b;
        int               cyc;

        burst = '{8'hAA, 8'h82, 8'hE2, 8'h92, 8'h8A, 8'h86, 8'h83};
        reset    = 1'b1;
        twr_en   = 1'b0;
        rrd_en   = 1'b0;
        twr_data = '0;
        tick(2);
        reset = 1'b0;

        check("reset_rx_empty", 32'(rx_empty), 32'd1);
        check("reset_rx_full",  32'(rx_full),  32'd0);
        check("reset_tx_full",  32'(tx_full),  32'd0);

        // Single byte: arrival latency window and head word
        write_byte(8'hAA);
        sb.push_back(8'hAA);
        wait_rx("single_arrive", 12 * BIT, cyc);
        check("single_latency_in_window", 32'(cyc >= 9 * BIT - 1 && cyc <= 11 * BIT), 32'd1);
        check("single_head", 32'(rrd_data), 32'hAA);
        drain("single_drain", 10);
        check("single_empty_after", 32'(rx_empty), 32'd1);

        // Seven back-to-back writes read with rrd_en held high
        foreach (burst[i]) begin
            write_byte(burst[i]);
            sb.push_back(burst[i]);
        end
        drain("seq7_drain", 8 * FRAME);
        check("seq7_empty_after", 32'(rx_empty), 32'd1);

        // TX FIFO overflow while the transmitter is busy with a leading byte
        write_byte(8'h11);
        sb.push_back(8'h11);
        tick(20);
        for (int i = 0; i < DEPTH + 2; i++) begin
            write_byte(8'(8'h40 + i));
            if (i < DEPTH) sb.push_back(8'(8'h40 + i));
            check($sformatf("txfull_after_write_%0d", i), 32'(tx_full), 32'(i >= DEPTH - 1));
        end
        drain("txovf_drain", (DEPTH + 3) * FRAME);
        tick(2 * FRAME);
        check("txovf_no_extra", 32'(rx_empty), 32'd1);

        // RX FIFO overflow: 18 frames arrive with no reads, only the first 16 are kept
        for (int i = 0; i < DEPTH + 2; i++) begin
            wait_not_full("rxovf_tx_ready", 2 * FRAME);
            b = 8'(i * 29 + 7);
            write_byte(b);
            if (i < DEPTH) sb.push_back(b);
        end
        tick((DEPTH + 2) * FRAME);
        check("rxovf_full",     32'(rx_full),  32'd1);
        check("rxovf_nonempty", 32'(rx_empty), 32'd0);
        drain("rxovf_drain", 2 * DEPTH + 4);
        check("rxovf_empty_after", 32'(rx_empty), 32'd1);
        check("rxovf_full_after",  32'(rx_full),  32'd0);

        // Reset in the middle of the second of two frames
        write_byte(8'h3C);
        write_byte(8'hC3);
        wait_rx("midrst_first_arrive", 2 * FRAME, cyc);
        tick(5 * BIT);
        do_reset();
        check("midrst_rx_empty", 32'(rx_empty), 32'd1);
        check("midrst_rx_full",  32'(rx_full),  32'd0);
        check("midrst_tx_full",  32'(tx_full),  32'd0);
        sb.delete();
        tick(3 * FRAME);
        check("midrst_no_partial_byte", 32'(rx_empty), 32'd1);

        // Reads while empty are ignored and leave the FIFO usable
        rrd_en = 1'b1;
        tick(5);
        check("emptyrd_rx_empty", 32'(rx_empty), 32'd1);
        check("emptyrd_rx_full",  32'(rx_full),  32'd0);
        rrd_en = 1'b0;
        write_byte(8'h5A);
        sb.push_back(8'h5A);
        wait_rx("emptyrd_arrive", 2 * FRAME, cyc);
        check("emptyrd_head", 32'(rrd_data), 32'h5A);
        drain("emptyrd_drain", 10);
        check("emptyrd_empty_after", 32'(rx_empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
